// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and framing constants for the instruction ROM loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, RUN, ERR} state_t;
  localparam int HDR_BYTES = 4;
  localparam int BYTES_PER_WORD = 4;
  function automatic logic last_byte(input logic [1:0] cnt, input int n);
    return cnt == 2'(n - 1);
  endfunction
endpackage

// File: rtl/inst_rom_mem.sv
// inst_rom_mem: DEPTH x 32 instruction array, synchronous write, asynchronous read.
module inst_rom_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: boot loader filling instruction memory from a byte stream, then releasing the core.
module inst_rom_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        ram_ce,
  input  logic [31:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        core_rst,
  output logic        loading,
  output logic        load_done,
  output logic        load_err
);
  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;
  state_t                state, state_nx;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [31:0]           len_reg;
  logic [23:0]           shift_q;
  logic [31:0]           word, rdata;
  logic                  xfer, hdr_last, word_last, we, last_word;
  logic                  unused_ok;
  assign xfer      = in_valid && in_ready;
  assign hdr_last  = xfer && last_byte(byte_cnt, HDR_BYTES);
  assign word_last = xfer && last_byte(byte_cnt, BYTES_PER_WORD);
  // Little-endian: the incoming byte completes the top of the word.
  assign word      = {in_data, shift_q};
  assign we        = state == DATA && word_last;
  assign last_word = {{(32-ADDR_WIDTH){1'b0}}, word_addr} == len_reg - 32'd1;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RUN, ERR: state_nx = load_start ? LEN : state;
      LEN:            state_nx = !hdr_last ? LEN : word == '0 ? RUN : {1'b0, word} > DEPTH ? ERR : DATA;
      DATA:           state_nx = we && last_word ? RUN : DATA;
      default:        state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      core_rst  <= 1'b1;
      in_ready  <= 1'b0;
      loading   <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      byte_cnt  <= '0;
      word_addr <= '0;
      len_reg   <= '0;
      shift_q   <= '0;
    end else begin
      state     <= state_nx;
      core_rst  <= state_nx != RUN;
      in_ready  <= state_nx inside {LEN, DATA};
      loading   <= state_nx inside {LEN, DATA};
      load_done <= state_nx == RUN && state != RUN;
      load_err  <= state_nx == ERR;
      if (state_nx == LEN && state != LEN) begin
        byte_cnt  <= '0;
        word_addr <= '0;
      end else begin
        if (xfer) begin
          byte_cnt <= byte_cnt + 2'd1;
          shift_q  <= word[31:8];
        end
        if (we) word_addr <= word_addr + 1'b1;
      end
      if (state == LEN && hdr_last) len_reg <= word;
    end
  inst_rom_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(word_addr),
    .wdata(word),
    .raddr(ram_addr[ADDR_WIDTH+1:2]),
    .rdata(rdata)
  );
  // Byte offset within a word is irrelevant to word fetches.
  assign unused_ok = ^ram_addr[1:0];
  assign ram_data  = ram_ce && ram_addr[31:ADDR_WIDTH+2] == '0 ? rdata : 32'd0;
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: vector table, directed corner sequences and randomized gapped loads against a memory model.
module tb_inst_rom_loader;
  logic        clk = 0, rst = 0, load_start = 0, in_valid = 0, ram_ce = 0;
  logic [7:0]  in_data = 0;
  logic [31:0] ram_addr = 0, ram_data;
  logic        in_ready, core_rst, loading, load_done, load_err;
  int          checks = 0, errors = 0;
  logic [31:0] mdl [1024];
  bit          known [1024];
  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [8];

  inst_rom_loader #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_ce(ram_ce), .ram_addr(ram_addr), .ram_data(ram_data),
    .core_rst(core_rst), .loading(loading), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rd(input logic ce, input logic [31:0] a, input logic [31:0] exp, input string name);
    ram_ce = ce;
    ram_addr = a;
    #1;
    chk(name, ram_data, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit done = 0;
    int n = 0;
    while (!done) begin
      @(negedge clk);
      chk("loading_during_load", {31'd0, loading}, 32'd1);
      load_start = gaps && ($urandom_range(0, 3) == 0);
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 0;
        in_data = 8'($urandom);
      end else begin
        in_valid = 1;
        in_data = b;
        done = in_ready;
      end
      if (++n > 200) begin
        errors++;
        $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        done = 1;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1;
    @(negedge clk);
    load_start = 0;
    chk("start_in_ready", {31'd0, in_ready}, 32'd1);
    chk("start_core_rst", {31'd0, core_rst}, 32'd1);
    chk("start_loading", {31'd0, loading}, 32'd1);
    chk("start_load_err", {31'd0, load_err}, 32'd0);
  endtask

  task automatic finish_load();
    @(negedge clk);
    in_valid = 0;
    load_start = 0;
    chk("done_pulse", {31'd0, load_done}, 32'd1);
    chk("done_core_rst", {31'd0, core_rst}, 32'd0);
    chk("done_loading", {31'd0, loading}, 32'd0);
    chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("done_once", {31'd0, load_done}, 32'd0);
    chk("run_core_rst", {31'd0, core_rst}, 32'd0);
  endtask

  task automatic load_img(input logic [31:0] ws[$], input bit gaps);
    start_load();
    send_word(32'(ws.size()), gaps);
    foreach (ws[i]) send_word(ws[i], gaps);
    finish_load();
    foreach (ws[i]) begin
      mdl[i] = ws[i];
      known[i] = 1;
    end
  endtask

  task automatic verify_mem();
    for (int i = 0; i < 16; i++)
      if (known[i]) check_rd(1, 32'(i * 4 + $urandom_range(0, 3)), mdl[i], "model_word");
  endtask

  initial begin
    logic [31:0] ws[$];
    vecs[0] = '{1'b1, 32'h0000_0000, 32'h3401_1100};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h3402_0020};
    vecs[2] = '{1'b1, 32'h0000_0008, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h0000_0000};
    vecs[4] = '{1'b1, 32'h0000_1000, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'h0000_0006, 32'h3402_0020};
    vecs[6] = '{1'b1, 32'h8000_0004, 32'h0000_0000};
    vecs[7] = '{1'b1, 32'h0000_0003, 32'h3401_1100};
    repeat (3) @(negedge clk);
    chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_loading", {31'd0, loading}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("idle_core_rst", {31'd0, core_rst}, 32'd1);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);

    ws = '{32'h3401_1100, 32'h3402_0020, 32'h0000_0000};
    load_img(ws, 0);
    foreach (vecs[i]) check_rd(vecs[i].ce, vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));

    ws = {};
    load_img(ws, 0);
    verify_mem();

    start_load();
    send_word(32'd1025, 0);
    @(negedge clk);
    in_valid = 0;
    chk("err_load_err", {31'd0, load_err}, 32'd1);
    chk("err_core_rst", {31'd0, core_rst}, 32'd1);
    chk("err_in_ready", {31'd0, in_ready}, 32'd0);
    chk("err_loading", {31'd0, loading}, 32'd0);
    @(negedge clk);
    chk("err_sticky", {31'd0, load_err}, 32'd1);
    start_load();
    send_word(32'd0, 0);
    finish_load();
    verify_mem();

    for (int t = 0; t < 6; t++) begin
      ws = {};
      repeat ($urandom_range(1, 6)) ws.push_back($urandom);
      load_img(ws, 1);
      verify_mem();
    end

    start_load();
    send_word(32'd1024, 0);
    send_word(32'hCAFE_F00D, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    in_valid = 0;
    chk("depth_ok_loading", {31'd0, loading}, 32'd1);
    chk("depth_ok_err", {31'd0, load_err}, 32'd0);
    mdl[0] = 32'hCAFE_F00D;
    known[0] = 1;
    #3 rst = 0;
    #1;
    chk("async_core_rst", {31'd0, core_rst}, 32'd1);
    chk("async_in_ready", {31'd0, in_ready}, 32'd0);
    chk("async_loading", {31'd0, loading}, 32'd0);
    verify_mem();
    @(negedge clk);
    rst = 1;
    ws = '{32'h1122_3344};
    load_img(ws, 0);
    verify_mem();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
